// File: rtl/dcache_core.sv
// Direct-mapped, write-back, no-write-allocate data cache array between the LSQ and miss controller.
// Optional DCACHE_STATS_EN adds registered hit/miss counters for loads and stores.
module dcache_core #(
    parameter int unsigned LSQSZ = 16,
    parameter int unsigned NSETS = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             except_i,
    input  logic             ld_en_i,
    input  logic [15:0]      ld_addr_i,
    input  logic [1:0]       ld_size_i,
    input  logic [LSQSZ-1:0] ld_gnt_i,
    input  logic             st_en_i,
    input  logic [15:0]      st_addr_i,
    input  logic [1:0]       st_size_i,
    input  logic [63:0]      st_data_i,
    output logic             hit_valid_o,
    output logic [LSQSZ-1:0] hit_gnt_o,
    output logic [31:0]      hit_data_o,
    output logic             rd_en_o,
    output logic [15:0]      rd_addr_o,
    output logic [LSQSZ-1:0] rd_gnt_o,
    output logic [1:0]       rd_size_o,
    output logic             wr_en_o,
    output logic [15:0]      wr_addr_o,
    output logic [63:0]      wr_data_o,
    output logic [1:0]       wr_size_o,
    output logic             wb_en_o,
    output logic [15:0]      wb_addr_o,
    output logic [63:0]      wb_data_o,
    output logic [1:0]       wb_size_o,
    input  logic             mem_wr_en_i,
    input  logic [4:0]       mem_wr_idx_i,
    input  logic [7:0]       mem_wr_tag_i,
    input  logic [63:0]      mem_wr_data_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]      ld_hits_o,
    output logic [31:0]      ld_misses_o,
    output logic [31:0]      st_hits_o,
    output logic [31:0]      st_misses_o
`endif
);

    logic        valid_q [NSETS];
    logic        dirty_q [NSETS];
    logic [7:0]  tag_q   [NSETS];
    logic [63:0] data_q  [NSETS];

    logic [4:0]  ld_idx, st_idx;
    logic [7:0]  ld_tag, st_tag;
    logic        ld_go, ld_hit_arr, ld_fill_hit, ld_hit;
    logic        st_hit, fill_do, st_to_fill, st_write_arr, st_in_victim, wb_need;
    logic [63:0] ld_line, ld_shift, ld_mask, st_merged, fill_line, victim_line;

    logic             hit_valid_d, rd_en_d, wr_en_d, wb_en_d;
    logic [LSQSZ-1:0] hit_gnt_d, rd_gnt_d;
    logic [31:0]      hit_data_d;
    logic [15:0]      rd_addr_d, wr_addr_d, wb_addr_d;
    logic [1:0]       rd_size_d, wr_size_d, wb_size_d;
    logic [63:0]      wr_data_d, wb_data_d;

    // Byte-enable merge; bytes shifted past offset 7 fall off the top of the line.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [2:0] off, input logic [1:0] size);
        logic [7:0]  size_be;
        logic [7:0]  be;
        logic [63:0] bitm;
        logic [63:0] shifted;
        unique case (size)
            2'd0:    size_be = 8'h01;
            2'd1:    size_be = 8'h03;
            2'd2:    size_be = 8'h0F;
            default: size_be = 8'hFF;
        endcase
        be      = size_be << off;
        shifted = data << {off, 3'b000};
        for (int b = 0; b < 8; b++) begin
            bitm[b*8 +: 8] = {8{be[b]}};
        end
        return (old & ~bitm) | (shifted & bitm);
    endfunction

    always_comb begin
        ld_idx = ld_addr_i[7:3];
        ld_tag = ld_addr_i[15:8];
        st_idx = st_addr_i[7:3];
        st_tag = st_addr_i[15:8];

        ld_go       = ld_en_i && !except_i;
        ld_hit_arr  = valid_q[ld_idx] && (tag_q[ld_idx] == ld_tag);
        ld_fill_hit = mem_wr_en_i && (mem_wr_idx_i == ld_idx) && (mem_wr_tag_i == ld_tag);
        ld_hit      = ld_hit_arr || ld_fill_hit;
        ld_line     = ld_hit_arr ? data_q[ld_idx] : mem_wr_data_i;
        ld_shift    = ld_line >> {ld_addr_i[2:0], 3'b000};
        unique case (ld_size_i)
            2'd0:    ld_mask = 64'h0000_0000_0000_00FF;
            2'd1:    ld_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    ld_mask = 64'h0000_0000_FFFF_FFFF;
            default: ld_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase

        // A fill matching a valid resident line is dropped: that line may hold newer dirty data.
        fill_do      = mem_wr_en_i &&
                       !(valid_q[mem_wr_idx_i] && (tag_q[mem_wr_idx_i] == mem_wr_tag_i));
        st_hit       = st_en_i && valid_q[st_idx] && (tag_q[st_idx] == st_tag);
        st_to_fill   = st_en_i && fill_do && (st_idx == mem_wr_idx_i) &&
                       (st_tag == mem_wr_tag_i);
        st_in_victim = st_hit && fill_do && (st_idx == mem_wr_idx_i);
        st_write_arr = st_hit && !st_in_victim;
        st_merged    = merge(data_q[st_idx], st_data_i, st_addr_i[2:0], st_size_i);
        fill_line    = st_to_fill ? merge(mem_wr_data_i, st_data_i, st_addr_i[2:0], st_size_i)
                                  : mem_wr_data_i;
        // A store hitting the line being displaced lands in the victim before it is written back.
        victim_line  = st_in_victim ? st_merged : data_q[mem_wr_idx_i];
        wb_need      = fill_do && valid_q[mem_wr_idx_i] && (dirty_q[mem_wr_idx_i] || st_in_victim);

        hit_valid_d = ld_go && ld_hit;
        hit_gnt_d   = hit_valid_d ? ld_gnt_i : '0;
        hit_data_d  = hit_valid_d ? ld_shift[31:0] & ld_mask[31:0] : 32'h0;
        rd_en_d     = ld_go && !ld_hit;
        rd_addr_d   = rd_en_d ? ld_addr_i : 16'h0;
        rd_gnt_d    = rd_en_d ? ld_gnt_i : '0;
        rd_size_d   = rd_en_d ? ld_size_i : 2'd0;
        wr_en_d     = st_en_i && !st_hit && !st_to_fill;
        wr_addr_d   = wr_en_d ? st_addr_i : 16'h0;
        wr_data_d   = wr_en_d ? st_data_i : 64'h0;
        wr_size_d   = wr_en_d ? st_size_i : 2'd0;
        wb_en_d     = wb_need;
        wb_addr_d   = wb_need ? {tag_q[mem_wr_idx_i], mem_wr_idx_i, 3'b000} : 16'h0;
        wb_data_d   = wb_need ? victim_line : 64'h0;
        wb_size_d   = wb_need ? 2'd3 : 2'd0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NSETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
            hit_valid_o <= 1'b0;
            hit_gnt_o   <= '0;
            hit_data_o  <= 32'h0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= 16'h0;
            rd_gnt_o    <= '0;
            rd_size_o   <= 2'd0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= 16'h0;
            wr_data_o   <= 64'h0;
            wr_size_o   <= 2'd0;
            wb_en_o     <= 1'b0;
            wb_addr_o   <= 16'h0;
            wb_data_o   <= 64'h0;
            wb_size_o   <= 2'd0;
        end else begin
            if (st_write_arr) begin
                data_q[st_idx]  <= st_merged;
                dirty_q[st_idx] <= 1'b1;
            end
            if (fill_do) begin
                data_q[mem_wr_idx_i]  <= fill_line;
                tag_q[mem_wr_idx_i]   <= mem_wr_tag_i;
                valid_q[mem_wr_idx_i] <= 1'b1;
                dirty_q[mem_wr_idx_i] <= st_to_fill;
            end
            hit_valid_o <= hit_valid_d;
            hit_gnt_o   <= hit_gnt_d;
            hit_data_o  <= hit_data_d;
            rd_en_o     <= rd_en_d;
            rd_addr_o   <= rd_addr_d;
            rd_gnt_o    <= rd_gnt_d;
            rd_size_o   <= rd_size_d;
            wr_en_o     <= wr_en_d;
            wr_addr_o   <= wr_addr_d;
            wr_data_o   <= wr_data_d;
            wr_size_o   <= wr_size_d;
            wb_en_o     <= wb_en_d;
            wb_addr_o   <= wb_addr_d;
            wb_data_o   <= wb_data_d;
            wb_size_o   <= wb_size_d;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ld_hits_o   <= 32'h0;
            ld_misses_o <= 32'h0;
            st_hits_o   <= 32'h0;
            st_misses_o <= 32'h0;
        end else begin
            if (hit_valid_d) ld_hits_o <= ld_hits_o + 32'd1;
            if (rd_en_d) ld_misses_o <= ld_misses_o + 32'd1;
            if (st_hit || st_to_fill) st_hits_o <= st_hits_o + 32'd1;
            if (wr_en_d) st_misses_o <= st_misses_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_core.sv
// Directed self-checking bench for dcache_core: reset, load/store hit/miss, fills, writebacks,
// same-cycle fill bypass and exception flush.
module tb_dcache_core;

    localparam int unsigned LSQSZ = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             except_s;
    logic             ld_en;
    logic [15:0]      ld_addr;
    logic [1:0]       ld_size;
    logic [LSQSZ-1:0] ld_gnt;
    logic             st_en;
    logic [15:0]      st_addr;
    logic [1:0]       st_size;
    logic [63:0]      st_data;
    logic             hit_valid;
    logic [LSQSZ-1:0] hit_gnt;
    logic [31:0]      hit_data;
    logic             rd_en;
    logic [15:0]      rd_addr;
    logic [LSQSZ-1:0] rd_gnt;
    logic [1:0]       rd_size;
    logic             wr_en;
    logic [15:0]      wr_addr;
    logic [63:0]      wr_data;
    logic [1:0]       wr_size;
    logic             wb_en;
    logic [15:0]      wb_addr;
    logic [63:0]      wb_data;
    logic [1:0]       wb_size;
    logic             mem_wr_en;
    logic [4:0]       mem_wr_idx;
    logic [7:0]       mem_wr_tag;
    logic [63:0]      mem_wr_data;
`ifdef DCACHE_STATS_EN
    logic [31:0]      ld_hits, ld_misses, st_hits, st_misses;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dcache_core #(.LSQSZ(LSQSZ), .NSETS(32)) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .except_i      (except_s),
        .ld_en_i       (ld_en),
        .ld_addr_i     (ld_addr),
        .ld_size_i     (ld_size),
        .ld_gnt_i      (ld_gnt),
        .st_en_i       (st_en),
        .st_addr_i     (st_addr),
        .st_size_i     (st_size),
        .st_data_i     (st_data),
        .hit_valid_o   (hit_valid),
        .hit_gnt_o     (hit_gnt),
        .hit_data_o    (hit_data),
        .rd_en_o       (rd_en),
        .rd_addr_o     (rd_addr),
        .rd_gnt_o      (rd_gnt),
        .rd_size_o     (rd_size),
        .wr_en_o       (wr_en),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .wr_size_o     (wr_size),
        .wb_en_o       (wb_en),
        .wb_addr_o     (wb_addr),
        .wb_data_o     (wb_data),
        .wb_size_o     (wb_size),
        .mem_wr_en_i   (mem_wr_en),
        .mem_wr_idx_i  (mem_wr_idx),
        .mem_wr_tag_i  (mem_wr_tag),
        .mem_wr_data_i (mem_wr_data)
`ifdef DCACHE_STATS_EN
        ,
        .ld_hits_o     (ld_hits),
        .ld_misses_o   (ld_misses),
        .st_hits_o     (st_hits),
        .st_misses_o   (st_misses)
`endif
    );

    task automatic clear_inputs();
        except_s    = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = 16'h0;
        ld_size     = 2'd0;
        ld_gnt      = '0;
        st_en       = 1'b0;
        st_addr     = 16'h0;
        st_size     = 2'd0;
        st_data     = 64'h0;
        mem_wr_en   = 1'b0;
        mem_wr_idx  = 5'd0;
        mem_wr_tag  = 8'h0;
        mem_wr_data = 64'h0;
    endtask

    // Apply current inputs across one rising edge, then sample registered outputs 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step_idle();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        ld_en = 1'b1; ld_addr = 16'h0108; ld_size = 2'd2; ld_gnt = 16'h0004;
        st_en = 1'b1; st_addr = 16'h0230; st_size = 2'd3;
        tick();
        tick();
        reset = 1'b0;
        tests++;
        if ({hit_valid, rd_en, wr_en, wb_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_enables: got %b expected 0000", {hit_valid, rd_en, wr_en, wb_en});
        end
        tests++;
        if ({rd_addr, wr_addr, wb_addr, hit_data} !== 80'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {rd_addr, wr_addr, wb_addr, hit_data});
        end
        step_idle();
    endtask

    task automatic test_load_miss();
        clear_inputs();
        ld_en = 1'b1; ld_addr = 16'h0108; ld_size = 2'd2; ld_gnt = 16'h0004;
        tick();
        tests++;
        if ({rd_en, rd_addr, rd_gnt, rd_size, hit_valid} !== {1'b1, 16'h0108, 16'h0004, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL load_miss: got en=%b addr=%h gnt=%h size=%0d hv=%b expected 1 0108 0004 2 0",
                     rd_en, rd_addr, rd_gnt, rd_size, hit_valid);
        end
        step_idle();
        tests++;
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL load_miss_one_cycle: got rd_en=%b expected 0", rd_en);
        end
    endtask

    task automatic test_fill_hit();
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd1; mem_wr_tag = 8'h01;
        mem_wr_data = 64'h1122334455667788;
        tick();
        tests++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL fill_invalid_no_wb: got wb_en=%b expected 0", wb_en);
        end
        clear_inputs();
        ld_en = 1'b1; ld_addr = 16'h010C; ld_size = 2'd2; ld_gnt = 16'h0001;
        tick();
        tests++;
        if ({hit_valid, hit_gnt, hit_data, rd_en} !== {1'b1, 16'h0001, 32'h11223344, 1'b0}) begin
            errors++;
            $display("FAIL load_hit_word: got hv=%b gnt=%h data=%h rd=%b expected 1 0001 11223344 0",
                     hit_valid, hit_gnt, hit_data, rd_en);
        end
        ld_addr = 16'h0109; ld_size = 2'd1; ld_gnt = 16'h0100;
        tick();
        tests++;
        if ({hit_valid, hit_gnt, hit_data} !== {1'b1, 16'h0100, 32'h00006677}) begin
            errors++;
            $display("FAIL load_hit_half: got hv=%b gnt=%h data=%h expected 1 0100 00006677",
                     hit_valid, hit_gnt, hit_data);
        end
        ld_addr = 16'h0108; ld_size = 2'd3;
        tick();
        tests++;
        if (hit_data !== 32'h55667788) begin
            errors++;
            $display("FAIL load_hit_double: got %h expected 55667788", hit_data);
        end
        step_idle();
    endtask

    task automatic test_store_wb();
        clear_inputs();
        st_en = 1'b1; st_addr = 16'h010A; st_size = 2'd0; st_data = 64'h00000000000000AB;
        tick();
        tests++;
        if ({wr_en, wb_en, hit_valid, rd_en} !== 4'b0000) begin
            errors++;
            $display("FAIL store_hit_silent: got %b expected 0000", {wr_en, wb_en, hit_valid, rd_en});
        end
        clear_inputs();
        ld_en = 1'b1; ld_addr = 16'h010A; ld_size = 2'd0; ld_gnt = 16'h0002;
        tick();
        tests++;
        if ({hit_valid, hit_data} !== {1'b1, 32'h000000AB}) begin
            errors++;
            $display("FAIL store_merged_byte: got hv=%b data=%h expected 1 000000ab", hit_valid, hit_data);
        end
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd1; mem_wr_tag = 8'h05;
        mem_wr_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        tests++;
        if ({wb_en, wb_addr, wb_data, wb_size} !== {1'b1, 16'h0108, 64'h1122334455AB7788, 2'd3}) begin
            errors++;
            $display("FAIL dirty_writeback: got en=%b addr=%h data=%h size=%0d expected 1 0108 1122334455ab7788 3",
                     wb_en, wb_addr, wb_data, wb_size);
        end
        clear_inputs();
        ld_en = 1'b1; ld_addr = 16'h050C; ld_size = 2'd2; ld_gnt = 16'h8000;
        tick();
        tests++;
        if ({hit_valid, hit_gnt, hit_data} !== {1'b1, 16'h8000, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_after_refill: got hv=%b gnt=%h data=%h expected 1 8000 deadbeef",
                     hit_valid, hit_gnt, hit_data);
        end
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd1; mem_wr_tag = 8'h06; mem_wr_data = 64'h1;
        tick();
        tests++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL clean_victim_no_wb: got wb_en=%b expected 0", wb_en);
        end
        step_idle();
    endtask

    task automatic test_store_miss();
        clear_inputs();
        st_en = 1'b1; st_addr = 16'h0230; st_size = 2'd3; st_data = 64'h0123456789ABCDEF;
        tick();
        tests++;
        if ({wr_en, wr_addr, wr_data, wr_size} !== {1'b1, 16'h0230, 64'h0123456789ABCDEF, 2'd3}) begin
            errors++;
            $display("FAIL store_miss: got en=%b addr=%h data=%h size=%0d expected 1 0230 0123456789abcdef 3",
                     wr_en, wr_addr, wr_data, wr_size);
        end
        clear_inputs();
        ld_en = 1'b1; ld_addr = 16'h0230; ld_size = 2'd3; ld_gnt = 16'h0010;
        tick();
        tests++;
        if ({rd_en, rd_addr, hit_valid} !== {1'b1, 16'h0230, 1'b0}) begin
            errors++;
            $display("FAIL no_write_allocate: got rd=%b addr=%h hv=%b expected 1 0230 0",
                     rd_en, rd_addr, hit_valid);
        end
        step_idle();
    endtask

    task automatic test_fill_bypass();
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd2; mem_wr_tag = 8'h03; mem_wr_data = 64'h0;
        ld_en = 1'b1; ld_addr = 16'h0310; ld_size = 2'd1; ld_gnt = 16'h0020;
        tick();
        tests++;
        if ({hit_valid, hit_gnt, hit_data, rd_en} !== {1'b1, 16'h0020, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL fill_bypass_zero: got hv=%b gnt=%h data=%h rd=%b expected 1 0020 0 0",
                     hit_valid, hit_gnt, hit_data, rd_en);
        end
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd3; mem_wr_tag = 8'h07;
        mem_wr_data = 64'hCAFEBABE_12345678;
        ld_en = 1'b1; ld_addr = 16'h071C; ld_size = 2'd2; ld_gnt = 16'h0040;
        tick();
        tests++;
        if ({hit_valid, hit_data, rd_en} !== {1'b1, 32'hCAFEBABE, 1'b0}) begin
            errors++;
            $display("FAIL fill_bypass_data: got hv=%b data=%h rd=%b expected 1 cafebabe 0",
                     hit_valid, hit_data, rd_en);
        end
        step_idle();
    endtask

    task automatic test_except();
        clear_inputs();
        except_s = 1'b1;
        ld_en = 1'b1; ld_addr = 16'h0400; ld_size = 2'd2; ld_gnt = 16'h0008;
        st_en = 1'b1; st_addr = 16'h0440; st_size = 2'd2; st_data = 64'h55;
        tick();
        tests++;
        if ({rd_en, hit_valid, wr_en, wr_addr} !== {1'b0, 1'b0, 1'b1, 16'h0440}) begin
            errors++;
            $display("FAIL except_flush: got rd=%b hv=%b wr=%b waddr=%h expected 0 0 1 0440",
                     rd_en, hit_valid, wr_en, wr_addr);
        end
        clear_inputs();
        except_s = 1'b1;
        ld_en = 1'b1; ld_addr = 16'h0310; ld_size = 2'd0; ld_gnt = 16'h0008;
        tick();
        tests++;
        if (hit_valid !== 1'b0) begin
            errors++;
            $display("FAIL except_drops_hit: got hv=%b expected 0", hit_valid);
        end
        step_idle();
    endtask

    task automatic test_fill_store_merge();
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd9; mem_wr_tag = 8'h0A; mem_wr_data = 64'h0;
        st_en = 1'b1; st_addr = 16'h0A4C; st_size = 2'd1; st_data = 64'h000000000000BEEF;
        tick();
        tests++;
        if ({wr_en, wb_en} !== 2'b00) begin
            errors++;
            $display("FAIL fill_store_no_wr: got wr=%b wb=%b expected 0 0", wr_en, wb_en);
        end
        clear_inputs();
        ld_en = 1'b1; ld_addr = 16'h0A4C; ld_size = 2'd2; ld_gnt = 16'h0200;
        tick();
        tests++;
        if ({hit_valid, hit_data} !== {1'b1, 32'h0000BEEF}) begin
            errors++;
            $display("FAIL fill_store_merged: got hv=%b data=%h expected 1 0000beef", hit_valid, hit_data);
        end
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd9; mem_wr_tag = 8'h0B; mem_wr_data = 64'h0;
        tick();
        tests++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 16'h0A48, 64'h0000BEEF_00000000}) begin
            errors++;
            $display("FAIL fill_store_dirty_wb: got en=%b addr=%h data=%h expected 1 0a48 0000beef00000000",
                     wb_en, wb_addr, wb_data);
        end
        step_idle();
    endtask

    task automatic test_back_to_back();
        // Word store at offset 7 keeps only its low byte; then rd/wr/wb in the same cycle.
        clear_inputs();
        st_en = 1'b1; st_addr = 16'h0B4F; st_size = 2'd2; st_data = 64'h11223344;
        tick();
        clear_inputs();
        ld_en = 1'b1; ld_addr = 16'h0B4C; ld_size = 2'd2; ld_gnt = 16'h0400;
        tick();
        tests++;
        if ({hit_valid, hit_data} !== {1'b1, 32'h44000000}) begin
            errors++;
            $display("FAIL store_overflow_discard: got hv=%b data=%h expected 1 44000000",
                     hit_valid, hit_data);
        end
        clear_inputs();
        mem_wr_en = 1'b1; mem_wr_idx = 5'd9; mem_wr_tag = 8'h0C; mem_wr_data = 64'h7;
        ld_en = 1'b1; ld_addr = 16'h0600; ld_size = 2'd0; ld_gnt = 16'h1000;
        st_en = 1'b1; st_addr = 16'h0700; st_size = 2'd0; st_data = 64'h9;
        tick();
        tests++;
        if ({rd_en, rd_addr, wr_en, wr_addr, wb_en, wb_addr, wb_data} !==
            {1'b1, 16'h0600, 1'b1, 16'h0700, 1'b1, 16'h0B48, 64'h4400000000000000}) begin
            errors++;
            $display("FAIL triple_issue: got rd=%b %h wr=%b %h wb=%b %h %h expected 1 0600 1 0700 1 0b48 4400000000000000",
                     rd_en, rd_addr, wr_en, wr_addr, wb_en, wb_addr, wb_data);
        end
        step_idle();
        tests++;
        if ({rd_en, wr_en, wb_en} !== 3'b000) begin
            errors++;
            $display("FAIL triple_one_cycle: got %b expected 000", {rd_en, wr_en, wb_en});
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_load_miss();
        test_fill_hit();
        test_store_wb();
        test_store_miss();
        test_fill_bypass();
        test_except();
        test_fill_store_merge();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/dcache_core.md
Name: dcache_core

Overview:
Direct-mapped, write-back, no-write-allocate data cache array. It sits between the LSQ and the dcache miss controller. It services LSQ loads and stores against 32 x 64-bit lines and returns load hits to the LSQ. It turns load misses, store misses and dirty-victim evictions into the controller's rd/wr/wb request streams, and it absorbs line fills returned by the controller.

Parameters:
LSQSZ, 16, LSQ entries; width of the one-hot load grant vector
NSETS, 32, number of lines; index = addr[7:3], tag = addr[15:8]

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
except  in  1  mispredict/exception flush of in-flight loads
ld_en  in  1  load request valid
ld_addr  in  16  load byte address
ld_size  in  2  0=BYTE 1=HALF 2=WORD 3=DOUBLE
ld_gnt  in  LSQSZ  one-hot LSQ entry of the load
st_en  in  1  store request valid
st_addr  in  16  store byte address
st_size  in  2  store size
st_data  in  64  store data, LSB-aligned
hit_valid  out  1  load hit response valid
hit_gnt  out  LSQSZ  LSQ entry of the hit
hit_data  out  32  load data, shifted and masked
rd_en / rd_addr / rd_gnt / rd_size  out  1/16/LSQSZ/2  load miss to controller
wr_en / wr_addr / wr_data / wr_size  out  1/16/64/2  store miss to controller
wb_en / wb_addr / wb_data / wb_size  out  1/16/64/2  dirty victim writeback; wb_size is always 3
mem_wr_en  in  1  fill valid from controller
mem_wr_idx  in  5  fill set index
mem_wr_tag  in  8  fill tag
mem_wr_data  in  64  fill line data

Behaviour:
- Reset: all valid and dirty bits are 0. All outputs are 0 on the cycle after reset is sampled high. Reset during a pending operation drops it and emits no outputs.
- All outputs are registered. A request sampled in cycle N produces its response in cycle N+1, held for exactly one cycle. There is no backpressure; the controller accepts every cycle.
- Lookup uses the array state at the start of the cycle. Hit = valid[idx] & tag[idx] == addr[15:8].
- Load hit:
  - hit_valid=1, hit_gnt=ld_gnt.
  - hit_data = low 32 bits of (line >> {addr[2:0],3'b0}) & mask.
  - mask is 8/16/32/64 ones for size 0/1/2/3.
- Load miss: rd_en=1, rd_addr=ld_addr, rd_gnt=ld_gnt, rd_size=ld_size.
- except=1 drops a load sampled that cycle: no hit_valid, no rd_en. Stores and fills are unaffected.
- Store hit:
  - Merge bytes addr[2:0] .. addr[2:0]+2^size-1 from st_data; bytes past offset 7 are discarded.
  - Set dirty. No output.
- Store miss: wr_en=1 with st_addr/st_data/st_size passed through. No allocation.
- Fill with valid & tag match: ignored. The resident line may hold newer dirty data.
- Fill otherwise: write data/tag, set valid, clear dirty.
  - If the displaced line was valid & dirty: wb_en=1, wb_addr={old_tag, idx, 3'b0}, wb_data=old line, wb_size=3.
- Fill and load in the same cycle, same idx, fill tag == load tag: the load is a hit and returns data from mem_wr_data. No rd_en.
- Fill and store in the same cycle, same idx, fill tag == store tag:
  - The store merges into the fill data and the line ends valid+dirty.
  - No wr_en. A writeback of the old victim is still emitted if required.
- Load and store in the same cycle are independent. The load sees pre-cycle line data; the LSQ guarantees ordering/forwarding.
- rd_en, wr_en and wb_en may all assert in the same cycle.

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds outputs ld_hits, ld_misses, st_hits, st_misses (each 32 bits, registered).
  - Each increments by 1 per qualifying request; loads are counted only if except=0.
  - Each wraps at 2^32 and clears on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, load 0x0108 size 2, gnt 0x0004 -> next cycle rd_en=1, rd_addr=0x0108, rd_gnt=0x0004, rd_size=2, hit_valid=0.
- Fill idx 1, tag 0x01, data 0x1122334455667788, then load 0x010C size 2, gnt 0x0001 -> hit_valid=1, hit_gnt=0x0001, hit_data=0x11223344.
- Store 0x010A size 0, data 0xAB; fill idx 1 tag 0x05 -> wb_en=1, wb_addr=0x0108, wb_data=0x1122334455AB7788, wb_size=3.
- Store 0x0230 size 3 to an invalid line -> wr_en=1, wr_addr=0x0230. A following load 0x0230 misses with rd_en=1.
- Same cycle: fill idx 2 tag 0x03 data 0 and load 0x0310 size 1 -> hit_valid=1, hit_data=0, no rd_en.
- Load miss with except=1 -> no rd_en and no hit_valid. A store in the same cycle still produces its wr_en.
